// File: rtl/clock_time_setter_if.sv
// Bus between the calendar counters and the time setter: running time in,
// shadow time, edit status and the commit strobe out.
interface clock_time_setter_if;
    logic [5:0]  cur_s, cur_mi;
    logic [4:0]  cur_h, cur_d;
    logic [3:0]  cur_mo;
    logic [13:0] cur_y;
    logic [5:0]  set_s, set_mi;
    logic [4:0]  set_h, set_d;
    logic [3:0]  set_mo;
    logic [13:0] set_y;
    logic        edit_active;
    logic [2:0]  field;
    logic        load;

    modport master (
        input  cur_s, cur_mi, cur_h, cur_d, cur_mo, cur_y,
        output set_s, set_mi, set_h, set_d, set_mo, set_y, edit_active, field, load
    );
    modport slave (
        output cur_s, cur_mi, cur_h, cur_d, cur_mo, cur_y,
        input  set_s, set_mi, set_h, set_d, set_mo, set_y, edit_active, field, load
    );
endinterface

// File: rtl/clock_time_setter.sv
// Operator time/date writer: debounces mode/inc keys, edits a shadow copy of
// the running calendar and commits it with a one-cycle load strobe.
module key_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1, sync2, level, level_q;
    logic [CW-1:0] cnt;

    // Idle (released) is high, so everything clears to 1 to avoid a false press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_q <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            level_q <= level;
            press   <= level_q & ~level;
            if (sync2 != level) begin
                if (cnt == CW'(DB_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module clock_time_setter #(
    parameter int          DB_CYCLES = 1_000_000,
    parameter logic [13:0] YEAR_RST  = 14'd2000
) (
    input  logic                  built_in_clk,
    input  logic                  glob_rst_n,
    input  logic                  key_mode_n,
    input  logic                  key_inc_n,
    clock_time_setter_if.master   bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, E_Y = 3'd1, E_MO = 3'd2, E_D = 3'd3,
        E_H = 3'd4, E_MI = 3'd5, E_S = 3'd6, COMMIT = 3'd7
    } state_t;

    state_t      state;
    logic [1:0]  press;
    logic        mode_ev, inc_ev;
    logic [5:0]  set_s, set_mi;
    logic [4:0]  set_h, set_d, dim;
    logic [3:0]  set_mo;
    logic [13:0] set_y;
    logic        edit_active, load;
    logic [2:0]  field;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [1:0] (
        .clk   (built_in_clk),
        .rst_n (glob_rst_n),
        .key_n ({key_inc_n, key_mode_n}),
        .press (press)
    );

    assign mode_ev = press[0];
    assign inc_ev  = press[1];

    function automatic logic [4:0] days_in(input logic [3:0] mo, input logic [13:0] y);
        logic leap;
        leap = ((y[1:0] == 2'b00) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
        case (mo)
            4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
            4'd2:                    days_in = leap ? 5'd29 : 5'd28;
            default:                 days_in = 5'd31;
        endcase
    endfunction

    always_comb dim = days_in(set_mo, set_y);

    // State field numbering doubles as the field code: E_Y=1 .. E_S=6.
    always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
        if (!glob_rst_n) begin
            state       <= IDLE;
            load        <= 1'b0;
            edit_active <= 1'b0;
            field       <= 3'd0;
            set_s       <= '0;
            set_mi      <= '0;
            set_h       <= '0;
            set_d       <= 5'd1;
            set_mo      <= 4'd1;
            set_y       <= YEAR_RST;
        end else begin
            load <= 1'b0;
            case (state)
                IDLE: if (mode_ev) begin
                    set_s       <= bus.cur_s;
                    set_mi      <= bus.cur_mi;
                    set_h       <= bus.cur_h;
                    set_d       <= bus.cur_d;
                    set_mo      <= bus.cur_mo;
                    set_y       <= bus.cur_y;
                    state       <= E_Y;
                    edit_active <= 1'b1;
                    field       <= 3'd1;
                end
                COMMIT: state <= IDLE;
                default: if (mode_ev) begin
                    if (state == E_S) begin
                        state       <= COMMIT;
                        load        <= 1'b1;
                        edit_active <= 1'b0;
                        field       <= 3'd0;
                    end else begin
                        state <= state_t'(state + 3'd1);
                        field <= field + 3'd1;
                    end
                    // Month/year are final once we leave E_MO; pull day into range.
                    if (state == E_MO && set_d > dim) set_d <= dim;
                end else if (inc_ev) begin
                    case (state)
                        E_Y:  set_y  <= (set_y == 14'd9999) ? 14'd0 : set_y + 14'd1;
                        E_MO: set_mo <= (set_mo >= 4'd12) ? 4'd1 : set_mo + 4'd1;
                        E_D:  set_d  <= (set_d >= dim) ? 5'd1 : set_d + 5'd1;
                        E_H:  set_h  <= (set_h >= 5'd23) ? 5'd0 : set_h + 5'd1;
                        E_MI: set_mi <= (set_mi >= 6'd59) ? 6'd0 : set_mi + 6'd1;
                        E_S:  set_s  <= (set_s >= 6'd59) ? 6'd0 : set_s + 6'd1;
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign bus.set_s       = set_s;
    assign bus.set_mi      = set_mi;
    assign bus.set_h       = set_h;
    assign bus.set_d       = set_d;
    assign bus.set_mo      = set_mo;
    assign bus.set_y       = set_y;
    assign bus.edit_active = edit_active;
    assign bus.field       = field;
    assign bus.load        = load;
endmodule
